uart_tx_frame: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 transmit-only block. Adds configurable data width, parity and stop-bit count, and a valid/ready input handshake with same-edge data capture. Supports gap-free back-to-back frames. Sits between a byte/word producer (e.g. perceptron result serializer) and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_tx_frame.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame state encoding and the
// bit-period helper. Used by uart_tx_frame and a future uart_rx_frame.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load sets the count, then it decrements to zero
// and holds there. tc flags the final cycle of the current bit period.
module uart_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Load has priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: configurable data width, parity and stop
// bits, valid/ready input with same-edge capture, gap-free back-to-back frames.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
//
// Handshake: a word is accepted on a rising edge where s_valid && s_ready.
// s_data is captured on that edge; s_valid while s_ready is low is ignored.
// s_ready is high in IDLE and in the very last cycle of the last stop bit,
// so an accept there starts the next start bit with no idle gap.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic          ODD_PARITY = (PARITY == PAR_ODD);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $fatal(1, "uart_tx_frame: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $fatal(1, "uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $fatal(1, "uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $fatal(1, "uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_e          state, state_d;
  logic                 tx_d;
  logic                 done_d;
  logic [DATA_BITS-1:0] sh;
  logic                 par_q;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [CW-1:0]        count;
  logic                 tc;
  logic                 load;
  logic                 capture;
  logic                 shift;
  logic                 bit_clr;
  logic                 bit_inc;
  logic                 stop_clr;
  logic                 stop_inc;
  logic                 accept;
  logic                 last_stop;
  logic                 break_active;

`ifdef UART_TX_BREAK_EN
  assign break_active = break_req;
`else
  assign break_active = 1'b0;
`endif

  uart_bit_timer #(
    .WIDTH (CW)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (BIT_LOAD),
    .count      (count),
    .tc         (tc)
  );

  assign last_stop = (stop_idx == STOP_LAST);
  assign s_ready   = ((state == ST_IDLE) || ((state == ST_STOP) && last_stop && tc))
                     && !break_active;
  assign accept    = s_valid && s_ready;
  // Look one cycle ahead so the registered done lands in the final stop cycle.
  assign done_d    = (state == ST_STOP) && last_stop && (count == CW'(1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, next tx level and datapath controls for each bit boundary.
  always_comb begin
    state_d  = state;
    tx_d     = tx;
    load     = 1'b0;
    capture  = 1'b0;
    shift    = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    stop_clr = 1'b0;
    stop_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_d = !break_active;
        if (accept) begin
          state_d = ST_START;
          tx_d    = 1'b0;
          load    = 1'b1;
          capture = 1'b1;
        end
      end
      ST_START: begin
        if (tc) begin
          state_d = ST_DATA;
          tx_d    = sh[0];
          shift   = 1'b1;
          load    = 1'b1;
          bit_clr = 1'b1;
        end
      end
      ST_DATA: begin
        if (tc) begin
          load = 1'b1;
          if (bit_idx == LAST_DATA) begin
            if (HAS_PARITY) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d  = ST_STOP;
              tx_d     = 1'b1;
              stop_clr = 1'b1;
            end
          end else begin
            tx_d    = sh[0];
            shift   = 1'b1;
            bit_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tc) begin
          state_d  = ST_STOP;
          tx_d     = 1'b1;
          load     = 1'b1;
          stop_clr = 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (tc) begin
          if (!last_stop) begin
            load     = 1'b1;
            stop_inc = 1'b1;
          end else if (accept) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            load    = 1'b1;
            capture = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Registered outputs plus shift register, parity and bit/stop indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sh       <= '0;
      par_q    <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      tx   <= tx_d;
      busy <= (state_d != ST_IDLE);
      done <= done_d;
      if (capture) begin
        sh    <= s_data;
        par_q <= (^s_data) ^ ODD_PARITY;
      end else if (shift) begin
        sh <= sh >> 1;
      end
      if (bit_clr) begin
        bit_idx <= '0;
      end else if (bit_inc) begin
        bit_idx <= bit_idx + 4'd1;
      end
      if (stop_clr) begin
        stop_idx <= 1'b0;
      end else if (stop_inc) begin
        stop_idx <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 7N2) at 10
// clocks per bit, checked cycle by cycle against a frame model.
module tb_uart_tx_frame;

  localparam int CPB = 10;
  localparam int NB  [4] = '{8, 8, 8, 7};
  localparam int PAR [4] = '{0, 1, 2, 0};
  localparam int STB [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_valid;
  logic [8:0] s_data [4];
  wire  [3:0] s_ready;
  wire  [3:0] tx;
  wire  [3:0] busy;
  wire  [3:0] done;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  // Expected per-cycle outputs packed as {s_ready, done, busy, tx}.
  logic [3:0] exp_q[$];
  logic [8:0] word_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0][7:0]),
    .tx(tx[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1][7:0]),
    .tx(tx[1]), .busy(busy[1]), .done(done[1]));

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2][7:0]),
    .tx(tx[2]), .busy(busy[2]), .done(done[2]));

  uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .s_valid(s_valid[3]), .s_ready(s_ready[3]), .s_data(s_data[3][6:0]),
    .tx(tx[3]), .busy(busy[3]), .done(done[3]));

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int frame_len(input int k);
    return CPB * (1 + NB[k] + ((PAR[k] != 0) ? 1 : 0) + STB[k]);
  endfunction

  // Line level of serial bit number idx within a frame carrying word w.
  function automatic logic model_bit(input int k, input logic [8:0] w, input int idx);
    int ones;
    ones = $countones(w);
    if (idx == 0) return 1'b0;
    if (idx <= NB[k]) return w[idx-1];
    if (PAR[k] != 0 && idx == NB[k] + 1) begin
      if (PAR[k] == 1) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  function automatic logic [8:0] rand_word(input int k);
    logic [8:0] m;
    m = 9'((1 << NB[k]) - 1);
    return 9'($urandom) & m;
  endfunction

  // ---------------- drivers ----------------
  // Sends every word in word_q on instance k, back to back, and compares all
  // outputs each cycle through the trailing idle cycle.
  task automatic send_frames(input int k);
    int n;
    int len;
    int f;
    logic [3:0] e;
    logic [3:0] got;
    n   = word_q.size();
    len = frame_len(k);
    exp_q.delete();
    for (int fi = 0; fi < n; fi++) begin
      for (int pos = 0; pos < len; pos++) begin
        exp_q.push_back({pos == len - 1, pos == len - 1, 1'b1, model_bit(k, word_q[fi], pos / CPB)});
      end
    end
    exp_q.push_back(4'b1001);
    @(negedge clk);
    check_eq($sformatf("k%0d pre_ready", k), 32'(s_ready[k]), 32'd1);
    s_valid[k] = 1'b1;
    s_data[k]  = word_q[0];
    for (int c = 1; c <= n * len + 1; c++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {s_ready[k], done[k], busy[k], tx[k]};
      check_eq($sformatf("k%0d c%0d tx", k, c), 32'(got[0]), 32'(e[0]));
      check_eq($sformatf("k%0d c%0d busy", k, c), 32'(got[1]), 32'(e[1]));
      check_eq($sformatf("k%0d c%0d done", k, c), 32'(got[2]), 32'(e[2]));
      check_eq($sformatf("k%0d c%0d ready", k, c), 32'(got[3]), 32'(e[3]));
      f = (c - 1) / len;
      if (c <= n * len && f + 1 < n) begin
        s_valid[k] = 1'b1;
        s_data[k]  = word_q[f + 1];
      end else begin
        s_valid[k] = 1'b0;
        s_data[k]  = ~word_q[(f < n) ? f : n - 1];
      end
    end
    s_valid[k] = 1'b0;
  endtask

  task automatic idle_cycles(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("k%0d idle tx", k), 32'(tx[k]), 32'd1);
      check_eq($sformatf("k%0d idle busy", k), 32'(busy[k]), 32'd0);
      check_eq($sformatf("k%0d idle ready", k), 32'(s_ready[k]), 32'd1);
      check_eq($sformatf("k%0d idle done", k), 32'(done[k]), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    s_valid = '0;
    for (int k = 0; k < 4; k++) s_data[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("k%0d rst tx", k), 32'(tx[k]), 32'd1);
      check_eq($sformatf("k%0d rst busy", k), 32'(busy[k]), 32'd0);
      check_eq($sformatf("k%0d rst done", k), 32'(done[k]), 32'd0);
      check_eq($sformatf("k%0d rst ready", k), 32'(s_ready[k]), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 single frame 0xA5
    word_q = '{9'h0A5};
    send_frames(0);
    idle_cycles(0, 3);

    // even and odd parity with 0x07
    word_q = '{9'h007};
    send_frames(1);
    word_q = '{9'h007};
    send_frames(2);

    // back-to-back 0x55 then 0xAA
    word_q = '{9'h055, 9'h0AA};
    send_frames(0);

    // 0x00 with s_data flipped to 0xFF right after accept
    word_q = '{9'h000};
    send_frames(0);

    // 7 data bits, 2 stop bits
    word_q = '{9'h041};
    send_frames(3);
    idle_cycles(3, 2);

    // asynchronous reset in the middle of data bit 3
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0]  = 9'h0C3;
    @(negedge clk);
    s_valid[0] = 1'b0;
    repeat (44) @(negedge clk);
    check_eq("mid busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst tx", 32'(tx[0]), 32'd1);
    check_eq("arst busy", 32'(busy[0]), 32'd0);
    check_eq("arst ready", 32'(s_ready[0]), 32'd1);
    check_eq("arst done", 32'(done[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    word_q = '{rand_word(0)};
    send_frames(0);

    // randomized bursts on every configuration
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        int n;
        n = $urandom_range(1, 3);
        word_q.delete();
        for (int i = 0; i < n; i++) word_q.push_back(rand_word(k));
        send_frames(k);
        idle_cycles(k, $urandom_range(0, 3));
      end
    end

`ifdef UART_TX_BREAK_EN
    // line break held 50 cycles in IDLE with a pending word
    @(negedge clk);
    check_eq("brk pre tx", 32'(tx[0]), 32'd1);
    break_req  = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0]  = 9'h05A;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("brk tx", 32'(tx[0]), 32'd0);
      check_eq("brk ready", 32'(s_ready[0]), 32'd0);
      check_eq("brk busy", 32'(busy[0]), 32'd0);
    end
    break_req  = 1'b0;
    s_valid[0] = 1'b0;
    idle_cycles(0, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
